// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and test-pattern mode encoding shared by the driver and its counter.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP + V_SYNC + V_BP;

  // Colour bars are a fixed width regardless of the active line length.
  localparam int BAR_WIDTH    = 80;

  typedef enum logic [1:0] {
    PAT_GRADIENT = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_SOLID    = 2'd2,
    PAT_CHECKER  = 2'd3
  } pat_mode_e;

  function automatic logic [7:0] rep2(input logic [1:0] f);
    return {4{f}};
  endfunction

endpackage

// File: rtl/vga_pixel_driver_if.sv
// Registered VGA pin bundle: sync/blank flags, complementary DAC codes and MSB copies.
interface vga_pixel_driver_if;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic [7:0] rn;
  logic [7:0] gn;
  logic [7:0] bn;
  logic       r7;
  logic       g7;
  logic       b7;
  logic       r6;
  logic       g6;
  logic       b6;

  modport master (
    output hsync, vsync, hblank, vblank,
    output r, g, b, rn, gn, bn,
    output r7, g7, b7, r6, g6, b6
  );

  modport slave (
    input hsync, vsync, hblank, vblank,
    input r, g, b, rn, gn, bn,
    input r7, g7, b7, r6, g6, b6
  );
endinterface

// File: rtl/vga_sync_counter.sv
// Pixel/line counters with unregistered sync and blank terms; latency 0 (combinational from hc/vc).
// No backpressure: free-running from the pixel clock.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       eof,
  output logic       hsync_c,
  output logic       vsync_c,
  output logic       hblank_c,
  output logic       vblank_c
);

  // Porch and sync widths stay fixed; only the active region scales.
  localparam int HT = H_TOTAL - H_ACTIVE_DEF + H_ACTIVE;
  localparam int VT = V_TOTAL - V_ACTIVE_DEF + V_ACTIVE;

  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic eol;

  assign eol = (hc == H_LAST);
  assign eof = eol && (vc == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (eol) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign hblank_c = (hc >= H_VIS);
  assign vblank_c = (vc >= V_VIS);
  assign hsync_c  = !((hc >= HS_START) && (hc < HS_END));
  assign vsync_c  = !((vc >= VS_START) && (vc < VS_END));

endmodule

// File: rtl/vga_pixel_driver.sv
// VGA 640x480@60 timing plus test-pattern generator; VGA_PIXEL_DRIVER_ANIM_EN scrolls modes 0/3 per frame.
// Latency 1 cycle from counter state to every pin; no backpressure (free-running pixel stream).
module vga_pixel_driver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                ui_in,
  vga_pixel_driver_if.master        vga
);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       eof;
  logic       hsync_c;
  logic       vsync_c;
  logic       hblank_c;
  logic       vblank_c;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .hc       (hc),
    .vc       (vc),
    .eof      (eof),
    .hsync_c  (hsync_c),
    .vsync_c  (vsync_c),
    .hblank_c (hblank_c),
    .vblank_c (vblank_c)
  );

  // Configuration is sampled once per frame at the start of vertical blanking,
  // so a change never tears the visible picture.
  logic [7:0] mode_q;
  pat_mode_e  mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
    end else if ((hc == '0) && (vc == 10'(V_ACTIVE))) begin
      mode_q <= ui_in;
    end
  end

  assign mode = pat_mode_e'(mode_q[1:0]);

  logic [7:0] hx;

`ifdef VGA_PIXEL_DRIVER_ANIM_EN
  logic [7:0] fc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc <= '0;
    end else if (eof) begin
      fc <= fc + 8'd1;
    end
  end

  assign hx = hc[7:0] + fc;
`else
  logic frame_end_unused;

  assign frame_end_unused = eof;
  assign hx               = hc[7:0];
`endif

  logic [2:0] bar;
  logic [7:0] r_d;
  logic [7:0] g_d;
  logic [7:0] b_d;

  assign bar = 3'(hc / 10'(BAR_WIDTH));

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode)
      PAT_GRADIENT: begin
        r_d = hx;
        g_d = vc[7:0];
        b_d = hc[7:0] ^ vc[7:0];
      end
      PAT_BARS: begin
        r_d = {8{bar[2]}};
        g_d = {8{bar[1]}};
        b_d = {8{bar[0]}};
      end
      PAT_SOLID: begin
        r_d = rep2(mode_q[7:6]);
        g_d = rep2(mode_q[5:4]);
        b_d = rep2(mode_q[3:2]);
      end
      PAT_CHECKER: begin
        r_d = {8{hx[5] ^ vc[5]}};
        g_d = r_d;
        b_d = r_d;
      end
      default: ;
    endcase
    if (hblank_c || vblank_c) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // p, n and MSB copies all load from r_d/g_d/b_d on the same edge, so a DAC
  // pair can never momentarily show equal levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.hsync  <= 1'b1;
      vga.vsync  <= 1'b1;
      vga.hblank <= 1'b1;
      vga.vblank <= 1'b1;
      vga.r      <= 8'h00;
      vga.g      <= 8'h00;
      vga.b      <= 8'h00;
      vga.rn     <= 8'hFF;
      vga.gn     <= 8'hFF;
      vga.bn     <= 8'hFF;
      vga.r7     <= 1'b0;
      vga.g7     <= 1'b0;
      vga.b7     <= 1'b0;
      vga.r6     <= 1'b0;
      vga.g6     <= 1'b0;
      vga.b6     <= 1'b0;
    end else begin
      vga.hsync  <= hsync_c;
      vga.vsync  <= vsync_c;
      vga.hblank <= hblank_c;
      vga.vblank <= vblank_c;
      vga.r      <= r_d;
      vga.g      <= g_d;
      vga.b      <= b_d;
      vga.rn     <= ~r_d;
      vga.gn     <= ~g_d;
      vga.bn     <= ~b_d;
      vga.r7     <= r_d[7];
      vga.g7     <= g_d[7];
      vga.b7     <= b_d[7];
      vga.r6     <= r_d[6];
      vga.g6     <= g_d[6];
      vga.b6     <= b_d[6];
    end
  end

endmodule

// File: tb/tb_vga_pixel_driver.sv
// Directed bench for vga_pixel_driver on a shortened raster (336x2 active, standard porches).
module tb_vga_pixel_driver;

  localparam int HA    = 336;
  localparam int VA    = 2;
  localparam int HT    = HA + 160;
  localparam int VT    = VA + 45;
  localparam int FRAME = HT * VT;

`ifdef VGA_PIXEL_DRIVER_ANIM_EN
  localparam logic [7:0] FC1 = 8'd1;
`else
  localparam logic [7:0] FC1 = 8'd0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;

  vga_pixel_driver_if vga ();

  vga_pixel_driver #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ui_in (ui_in),
    .vga   (vga)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // sync field is {hsync, vsync, hblank, vblank}
  typedef struct {
    int         f;
    int         y;
    int         x;
    logic [7:0] ui_next;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [3:0] sync;
  } vec_t;

  vec_t vt[32];
  int   nv = 0;

  // Continuous observers: pair/MSB invariants always, timing counts over frame 0.
  bit mon_en    = 1'b1;
  int pn_viol   = 0;
  int msb_viol  = 0;
  int hs_low    = 0;
  int hs_first  = 0;
  int hb_high   = 0;
  int vs_low    = 0;
  int vb_high   = 0;
  int fall1     = 0;
  int fall2     = 0;
  bit prev_vs   = 1'b1;

  always @(negedge clk) begin
    if ((vga.rn !== ~vga.r) || (vga.gn !== ~vga.g) || (vga.bn !== ~vga.b))
      pn_viol <= pn_viol + 1;
    if ({vga.r7, vga.r6, vga.g7, vga.g6, vga.b7, vga.b6} !==
        {vga.r[7:6], vga.g[7:6], vga.b[7:6]})
      msb_viol <= msb_viol + 1;
    if (mon_en && rst_n) begin
      if (cyc >= 1 && cyc <= HT) begin
        if (!vga.hsync) begin
          hs_low <= hs_low + 1;
          if (hs_first == 0) hs_first <= cyc;
        end
        if (vga.hblank) hb_high <= hb_high + 1;
      end
      if (cyc >= 1 && cyc <= FRAME) begin
        if (!vga.vsync) vs_low <= vs_low + 1;
        if (vga.vblank) vb_high <= vb_high + 1;
      end
      if (prev_vs && !vga.vsync) begin
        if (fall1 == 0) fall1 <= cyc;
        else if (fall2 == 0) fall2 <= cyc;
      end
      prev_vs <= vga.vsync;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
  endtask

  // Advance to just after edge n (edge n shows the counter state n-1 since release).
  task automatic go_to(input int n);
    if (cyc >= n) begin
      errors++;
      $display("FAIL seq: edge %0d already passed at %0d", n, cyc);
    end
    while (cyc < n) tick();
    #2;
  endtask

  function automatic int pix(input int f, input int y, input int x);
    return f * FRAME + y * HT + x + 1;
  endfunction

  task automatic add(input int f, input int y, input int x, input logic [7:0] ui,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [3:0] s);
    vt[nv] = '{f, y, x, ui, r, g, b, s};
    nv++;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, " r"},    {8'h0, vga.r, vga.g, vga.b}, 32'h0000_0000);
    chk({tag, " n"},    {8'h0, vga.rn, vga.gn, vga.bn}, 32'h00FF_FFFF);
    chk({tag, " sync"}, {28'h0, vga.hsync, vga.vsync, vga.hblank, vga.vblank}, 32'hF);
    chk({tag, " msb"},  {26'h0, vga.r7, vga.r6, vga.g7, vga.g6, vga.b7, vga.b6}, 32'h0);
  endtask

  initial begin
    // frame 0: gradient, static in both builds
    add(0,  0,   0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1100);
    add(0,  0,   5, 8'h00, 8'h05, 8'h00, 8'h05, 4'b1100);
    add(0,  1, 200, 8'h00, 8'hC8, 8'h01, 8'hC9, 4'b1100);
    add(0,  1, 300, 8'h00, 8'h2C, 8'h01, 8'h2D, 4'b1100);
    add(0,  1, 340, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1110);
    add(0,  1, 360, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0110);
    add(0,  1, 447, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0110);
    add(0,  1, 448, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1110);
    add(0, 12,   0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1001);
    add(0, 14,   0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1101);
    // frame 1: gradient with fc=1 when animated; request solid 101101b mid-frame
    add(1,  0,  10, 8'hB6, 8'h0A + FC1, 8'h00, 8'h0A, 4'b1100);
    add(1,  1, 100, 8'hB6, 8'h64 + FC1, 8'h01, 8'h65, 4'b1100);
    // frame 2: solid; request colour bars mid-frame
    add(2,  0,   0, 8'h01, 8'hAA, 8'hFF, 8'h55, 4'b1100);
    add(2,  1, 335, 8'h01, 8'hAA, 8'hFF, 8'h55, 4'b1100);
    add(2,  1, 336, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1110);
    add(2,  2,   0, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1101);
    // frame 3: colour bars
    add(3,  0,   0, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1100);
    add(3,  0, 100, 8'h01, 8'h00, 8'h00, 8'hFF, 4'b1100);
    add(3,  0, 250, 8'h01, 8'h00, 8'hFF, 8'hFF, 4'b1100);
    add(3,  0, 330, 8'h01, 8'hFF, 8'h00, 8'h00, 4'b1100);
    add(3,  0, 336, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1110);

    repeat (3) @(posedge clk);
    #2;
    chk_reset_pins("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    for (int i = 0; i < nv; i++) begin
      go_to(pix(vt[i].f, vt[i].y, vt[i].x));
      chk($sformatf("v%0d rgb", i), {8'h0, vga.r, vga.g, vga.b},
          {8'h0, vt[i].r, vt[i].g, vt[i].b});
      chk($sformatf("v%0d n", i), {8'h0, vga.rn, vga.gn, vga.bn},
          {8'h0, ~vt[i].r, ~vt[i].g, ~vt[i].b});
      chk($sformatf("v%0d sync", i), {28'h0, vga.hsync, vga.vsync, vga.hblank, vga.vblank},
          {28'h0, vt[i].sync});
      ui_in = vt[i].ui_next;
    end

    chk("hsync low count", hs_low, HT - HA - 64);
    chk("hsync first low", hs_first, HA + 16 + 1);
    chk("hblank count", hb_high, 160);
    chk("vsync low count", vs_low, 2 * HT);
    chk("vblank count", vb_high, 45 * HT);
    chk("frame period", fall2 - fall1, FRAME);

    // Reset mid-line while bars are showing
    go_to(pix(3, 1, 100));
    chk("pre-reset b", {24'h0, vga.b}, 32'hFF);
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_pins("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    go_to(pix(0, 0, 0));
    chk("restart rgb", {8'h0, vga.r, vga.g, vga.b}, 32'h0);
    chk("restart sync", {28'h0, vga.hsync, vga.vsync, vga.hblank, vga.vblank}, 32'hC);
    go_to(pix(0, 0, 20));
    chk("restart gradient", {8'h0, vga.r, vga.g, vga.b}, 32'h0014_0014);

    chk("pn complement", pn_viol, 0);
    chk("msb copies", msb_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
